// File: rtl/pipeline_stall_controller.sv
// Purpose: central stall/flush/halt controller driving PC and IF/ID/ID-EX enables.
// Latency: enables are combinational from state+inputs; state/counters update next edge.
// Backpressure: memBusy freezes the whole pipeline and holds all controller state.
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        memBusy,
    input  logic        branchTaken,
    input  logic        haltReq,
    input  logic        resume,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic [1:0]  ctrlState,
    output logic [3:0]  stallCount,
    output logic        stallTimeout,
    output logic [15:0] stallTotal
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Remaining flush cycles after the branch cycle itself.
    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_total_q, stall_total_d;

    // Priority resolution: reset > halt > memBusy > branch/flush > hazard > none.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_d     = timeout_q;
        stall_total_d = stall_total_q;
        pcWrite       = 1'b1;
        ifIdWrite     = 1'b1;
        ifIdFlush     = 1'b0;
        idExBubble    = 1'b0;

        if (reset) begin
            // Registered state is cleared by the sequential block; only outputs here.
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            state_d    = ST_RUN;
        end else if (state_q == ST_HALT || haltReq) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b0;
            idExBubble = 1'b1;
            // Leaving HALT needs resume with no competing halt request.
            if (state_q == ST_HALT && resume && !haltReq) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_HALT;
            end
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b0;
            idExBubble = 1'b0;
        end else if (branchTaken || state_q == ST_FLUSH) begin
            pcWrite     = 1'b1;
            ifIdWrite   = 1'b1;
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
            stall_cnt_d = 4'd0;
            if (branchTaken) begin
                // A new branch always restarts the flush window.
                flush_cnt_d = FLUSH_LOAD;
                state_d     = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (flush_cnt_q <= 3'd1) begin
                flush_cnt_d = 3'd0;
                state_d     = ST_RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                state_d     = ST_FLUSH;
            end
        end else if (hazard) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b0;
            idExBubble = 1'b1;
            state_d    = ST_STALL;
            if (stall_cnt_q != 4'hF) begin
                stall_cnt_d = stall_cnt_q + 4'd1;
            end
            if (stall_total_q != 16'hFFFF) begin
                stall_total_d = stall_total_q + 16'd1;
            end
            if (stall_cnt_d == STALL_LIMIT) begin
                timeout_d = 1'b1;
            end
        end else begin
            state_d     = ST_RUN;
            stall_cnt_d = 4'd0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush counter, stall counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q   <= 3'd0;
            stall_cnt_q   <= 4'd0;
            timeout_q     <= 1'b0;
            stall_total_q <= 16'd0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_q     <= timeout_d;
            stall_total_q <= stall_total_d;
        end
    end

    assign ctrlState    = state_q;
    assign stallCount   = stall_cnt_q;
    assign stallTimeout = timeout_q;
    assign stallTotal   = stall_total_q;

endmodule
